// File: rtl/fb_scanout.sv
// Framebuffer scan-out engine: fetches a rectangular frame from memory in
// raster order, buffers it in a small FIFO and streams it out as pixels
// with start-of-frame / end-of-line markers.
module fb_scanout #(
   parameter int H_ACTIVE   = 320,
   parameter int V_ACTIVE   = 240,
   parameter int STRIDE     = 320,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic              i_buf_sel,
   input  logic [ADDR_W-1:0] i_base0,
   input  logic [ADDR_W-1:0] i_base1,
   output logic              o_mem_rd,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_pix_valid,
   input  logic              i_pix_ready,
   output logic [DATA_W-1:0] o_pix_data,
   output logic              o_pix_sof,
   output logic              o_pix_eol,
   output logic              o_frame_done,
   output logic              o_busy
);

   localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [X_W-1:0]    X_LAST   = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // fetch side
   logic [X_W-1:0]    r_fx;
   logic [Y_W-1:0]    r_fy;
   logic [ADDR_W-1:0] r_line_base;
   logic [ADDR_W-1:0] r_addr;
   logic              r_inflight;

   // pixel buffer
   logic [DATA_W-1:0] r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   // output side
   logic [X_W-1:0]    r_ox;
   logic [Y_W-1:0]    r_oy;
   logic              r_frame_done;

   logic              w_latch;
   logic              w_mem_rd;
   logic              w_fetch_last;
   logic              w_drained;
   logic              w_push;
   logic              w_pop;
   logic [CNT_W-1:0]  w_occupancy;
   logic [ADDR_W-1:0] w_base_sel;

   assign w_base_sel   = i_buf_sel ? i_base1 : i_base0;
   // Occupancy counts the read already on the bus so its data always has a slot.
   assign w_occupancy  = r_count + CNT_W'(r_inflight);
   assign w_fetch_last = (r_fx == X_LAST) && (r_fy == Y_LAST);
   assign w_drained    = (r_count == '0) && !r_inflight;
   assign w_push       = r_inflight;
   assign w_pop        = o_pix_valid && i_pix_ready;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state, frame latch and read-issue decision.
   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      w_mem_rd     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_enable) begin
               w_latch      = 1'b1;
               w_state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (w_occupancy < DEPTH_C) begin
               w_mem_rd = 1'b1;
               if (w_fetch_last) w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drained) begin
               if (i_enable) begin
                  w_latch      = 1'b1;
                  w_state_next = S_FETCH;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Fetch position and address, stepped incrementally (no multiplier).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fx        <= '0;
         r_fy        <= '0;
         r_line_base <= '0;
         r_addr      <= '0;
      end else if (w_latch) begin
         r_fx        <= '0;
         r_fy        <= '0;
         r_line_base <= w_base_sel;
         r_addr      <= w_base_sel;
      end else if (w_mem_rd) begin
         if (r_fx == X_LAST) begin
            r_fx        <= '0;
            r_fy        <= r_fy + Y_W'(1);
            r_line_base <= r_line_base + STRIDE_A;
            r_addr      <= r_line_base + STRIDE_A;
         end else begin
            r_fx   <= r_fx + X_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   // Remember last cycle's read so its data is captured on the following edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_inflight <= 1'b0;
      else          r_inflight <= w_mem_rd;
   end

   // FIFO storage; contents need no reset because the count gates the output.
   always_ff @(posedge i_clk) begin
      if (w_push) r_fifo_mem[r_wr_ptr] <= i_mem_rdata;
   end

   // FIFO pointers and count; simultaneous push and pop keeps the count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output raster position and end-of-frame pulse, advanced per accepted pixel.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ox         <= '0;
         r_oy         <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_pop && (r_ox == X_LAST) && (r_oy == Y_LAST);
         if (w_pop) begin
            if (r_ox == X_LAST) begin
               r_ox <= '0;
               r_oy <= (r_oy == Y_LAST) ? '0 : r_oy + Y_W'(1);
            end else begin
               r_ox <= r_ox + X_W'(1);
            end
         end
      end
   end

   assign o_mem_rd     = w_mem_rd;
   assign o_mem_addr   = r_addr;
   assign o_pix_valid  = (r_count != '0);
   assign o_pix_data   = o_pix_valid ? r_fifo_mem[r_rd_ptr] : '0;
   assign o_pix_sof    = o_pix_valid && (r_ox == '0) && (r_oy == '0);
   assign o_pix_eol    = o_pix_valid && (r_ox == X_LAST);
   assign o_frame_done = r_frame_done;
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: expected addresses and pixels are queued
// when a frame is requested; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_fb_scanout;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        buf_sel = 1'b0;
   logic [15:0] base0 = 16'h0000;
   logic [15:0] base1 = 16'h0000;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic [31:0] pix_data;
   logic        pix_sof;
   logic        pix_eol;
   logic        frame_done;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int rd_count = 0;
   int pop_count = 0;
   int fd_count = 0;

   logic [15:0] exp_addr [$];
   logic [33:0] exp_pix  [$];   // {eol, sof, data}

   // Hand-computed address sequences (H=4, V=2, STRIDE=6).
   logic [15:0] vec [3][8] = '{
      '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0106, 16'h0107, 16'h0108, 16'h0109},
      '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0206, 16'h0207, 16'h0208, 16'h0209},
      '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0004, 16'h0005, 16'h0006, 16'h0007}
   };

   fb_scanout #(
      .H_ACTIVE(4), .V_ACTIVE(2), .STRIDE(6),
      .ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_enable(enable),
      .i_buf_sel(buf_sel),
      .i_base0(base0),
      .i_base1(base1),
      .o_mem_rd(mem_rd),
      .o_mem_addr(mem_addr),
      .i_mem_rdata(mem_rdata),
      .o_pix_valid(pix_valid),
      .i_pix_ready(pix_ready),
      .o_pix_data(pix_data),
      .o_pix_sof(pix_sof),
      .o_pix_eol(pix_eol),
      .o_frame_done(frame_done),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model: data is a tag plus the address, one cycle after the read.
   always @(posedge clk) begin
      mem_rdata <= mem_rd ? {16'hC0DE, mem_addr} : 32'h0;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
      end
   endtask

   task automatic push_frame(input int k);
      for (int i = 0; i < 8; i++) begin
         exp_addr.push_back(vec[k][i]);
         exp_pix.push_back({(i == 3 || i == 7), (i == 0), 16'hC0DE, vec[k][i]});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_zero(input string nm);
      check(nm, {mem_rd, mem_addr, pix_valid, pix_data, pix_sof, pix_eol, frame_done, busy}, 64'h0);
   endtask

   task automatic wait_fd(input int n, input int budget);
      int c = 0;
      while (fd_count < n && c < budget) begin
         tick();
         c++;
      end
      check("frame_done_count", fd_count, n);
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      check("busy_after_frame", busy, 1'b0);
      check("scoreboard_empty", exp_addr.size() + exp_pix.size(), 0);
   endtask

   // Monitor: compares every read strobe and every accepted pixel.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_rd) begin
            rd_count++;
            if (exp_addr.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_read: got addr 0x%0h, none required", mem_addr);
            end else begin
               check("mem_addr", mem_addr, exp_addr.pop_front());
            end
         end
         if (pix_valid && pix_ready) begin
            pop_count++;
            $display("[TB] pop %0d data=%h sof=%b eol=%b", pop_count, pix_data, pix_sof, pix_eol);
            if (exp_pix.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pixel: got 0x%0h, none required", pix_data);
            end else begin
               check("pixel{eol,sof,data}", {pix_eol, pix_sof, pix_data}, exp_pix.pop_front());
            end
         end
         if (frame_done) fd_count++;
      end
   end

   // Stimulus.
   initial begin
      int rd0;
      int p0;
      int c;

      // Reset with enable asserted: everything stays quiet.
      enable = 1'b1;
      base0  = 16'h0100;
      #1 rst_n = 1'b0;
      #1 check_zero("reset_async");
      for (int i = 0; i < 4; i++) begin
         tick();
         check_zero("reset_hold");
      end
      enable = 1'b0;
      rst_n  = 1'b1;
      tick();
      check("idle_after_reset", busy, 1'b0);

      // Basic frame with latency checks.
      push_frame(0);
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("latency_mem_rd", mem_rd, 1'b1);
      check("latency_valid_e1", pix_valid, 1'b0);
      enable = 1'b0;
      @(posedge clk);
      #1 check("latency_valid_e2", pix_valid, 1'b0);
      @(posedge clk);
      #1 check("latency_valid_e3", pix_valid, 1'b1);
      wait_fd(1, 60);
      wait_idle(20);
      repeat (3) tick();
      check("stays_idle", busy, 1'b0);
      check("single_frame_done", fd_count, 1);

      // Backpressure: FIFO fills to four entries and fetching stops.
      pix_ready = 1'b0;
      push_frame(0);
      rd0 = rd_count;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      repeat (10) tick();
      check("bp_reads_issued", rd_count - rd0, 4);
      check("bp_mem_rd_low", mem_rd, 1'b0);
      check("bp_valid_held", pix_valid, 1'b1);
      pix_ready = 1'b1;
      wait_fd(2, 60);
      wait_idle(20);

      // Buffer switch mid-frame with enable held; base changes mid-frame ignored.
      push_frame(0);
      push_frame(1);
      base1   = 16'h0200;
      buf_sel = 1'b0;
      enable  = 1'b1;
      repeat (3) tick();
      buf_sel = 1'b1;
      base0   = 16'h0700;
      wait_fd(3, 60);
      repeat (2) tick();
      enable = 1'b0;
      base1  = 16'h0300;
      wait_fd(4, 60);
      wait_idle(20);

      // Address wrap at the top of the address space.
      buf_sel = 1'b0;
      base0   = 16'hFFFE;
      push_frame(2);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      wait_fd(5, 60);
      wait_idle(20);

      // Abort mid-frame via reset, then restart from pixel (0,0).
      base0 = 16'h0100;
      push_frame(0);
      p0 = pop_count;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      c = 0;
      while (pop_count < p0 + 3 && c < 40) begin
         tick();
         c++;
      end
      check("abort_pops_before_reset", pop_count - p0, 3);
      rst_n = 1'b0;
      #1 check_zero("abort_reset_async");
      exp_addr.delete();
      exp_pix.delete();
      repeat (2) tick();
      check_zero("abort_reset_hold");
      push_frame(0);
      enable = 1'b1;
      rst_n  = 1'b1;
      tick();
      enable = 1'b0;
      wait_fd(6, 60);
      wait_idle(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
      $fatal(1, "watchdog");
   end

endmodule
